// File: rtl/ocp_pkg.sv
// Shared OCP basic-group encodings and the slave FSM state encoding used by both
// ends of the PCIe<->OCP bridge.
package ocp_pkg;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_FAIL = 2'b10;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_XFER   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic logic is_rw(input logic [2:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/ocp_timeout_counter.sv
// Saturating cycle counter bounding how long the slave waits for a target ack.
// expired is high while the count sits at TIMEOUT.
module ocp_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic Clk,
  input  logic reset,
  input  logic ce,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;

  assign expired = (timer == TW'(TIMEOUT));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (ce) begin
      if (clear)
        timer <= '0;
      else if (count_en && !expired)
        timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP basic-group slave: accepts one WR/RD at a time, drives the bridge-side target
// port, and holds SResp/SData until the master accepts the response.
module ocp_slave_fsm
  import ocp_pkg::*;
#(
  parameter int ADDR_WDTH  = 64,
  parameter int DATA_WDTH  = 8,
  parameter int TIMEOUT    = 255,
  parameter bit WRITE_RESP = 1'b0
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 EnableClk,
  input  logic [2:0]           MCmd,
  input  logic [ADDR_WDTH-1:0] MAddr,
  input  logic [DATA_WDTH-1:0] MData,
  input  logic                 MRespAccept,
  output logic                 SCmdAccept,
  output logic [1:0]           SResp,
  output logic [DATA_WDTH-1:0] SData,
  output logic [ADDR_WDTH-1:0] address,
  output logic [DATA_WDTH-1:0] write_data,
  output logic                 write_request,
  output logic                 read_request,
  input  logic [DATA_WDTH-1:0] read_data,
  input  logic                 tgt_ack,
  input  logic                 tgt_error
);

  logic [1:0] state;
  logic [2:0] cmd_q;
  logic       expired;
  logic       in_xfer;

  assign in_xfer       = (state == ST_XFER);
  assign SCmdAccept    = (state == ST_ACCEPT);
  assign write_request = in_xfer && (cmd_q == CMD_WR);
  assign read_request  = in_xfer && (cmd_q == CMD_RD);

  ocp_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .Clk      (Clk),
    .reset    (reset),
    .ce       (EnableClk),
    .clear    (!in_xfer),
    .count_en (in_xfer),
    .expired  (expired)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd_q      <= CMD_IDLE;
      SResp      <= SRESP_NULL;
      SData      <= '0;
      address    <= '0;
      write_data <= '0;
    end else if (EnableClk) begin
      case (state)
        ST_IDLE: begin
          if (MCmd != CMD_IDLE) begin
            cmd_q      <= MCmd;
            address    <= MAddr;
            write_data <= MData;
            state      <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (is_rw(cmd_q)) begin
            state <= ST_XFER;
          end else begin
            SResp <= SRESP_ERR;
            SData <= '0;
            state <= ST_RESP;
          end
        end
        ST_XFER: begin
          // An ack in the same cycle as the timeout takes priority over it.
          if (tgt_ack && !tgt_error) begin
            if (cmd_q == CMD_RD) begin
              SResp <= SRESP_DVA;
              SData <= read_data;
              state <= ST_RESP;
            end else if (WRITE_RESP) begin
              SResp <= SRESP_DVA;
              state <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tgt_ack || expired) begin
            if (cmd_q == CMD_WR && !WRITE_RESP) begin
              state <= ST_IDLE;
            end else begin
              SResp <= SRESP_ERR;
              SData <= '0;
              state <= ST_RESP;
            end
          end
        end
        default: begin
          if (MRespAccept) begin
            SResp <= SRESP_NULL;
            SData <= '0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Directed bench for ocp_slave_fsm: stimulus pushes expected target requests and
// responses into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_ocp_slave_fsm;

  localparam int AW = 64;
  localparam int DW = 8;

  typedef struct {
    logic [1:0]    kind;   // {write_request, read_request}
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } rsp_t;

  logic          Clk = 1'b0;
  logic          reset;
  logic          EnableClk;
  logic [2:0]    MCmd;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MData;
  logic          MRespAccept;
  logic          SCmdAccept;
  logic [1:0]    SResp;
  logic [DW-1:0] SData;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          write_request;
  logic          read_request;
  logic [DW-1:0] read_data;
  logic          tgt_ack;
  logic          tgt_error;

  int total = 0;
  int bad   = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];

  ocp_slave_fsm #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .TIMEOUT(4), .WRITE_RESP(1'b0)
  ) dut (
    .Clk(Clk), .reset(reset), .EnableClk(EnableClk),
    .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MRespAccept(MRespAccept),
    .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData),
    .address(address), .write_data(write_data),
    .write_request(write_request), .read_request(read_request),
    .read_data(read_data), .tgt_ack(tgt_ack), .tgt_error(tgt_error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: responses and target requests are checked against the queues.
  logic       resp_active = 1'b0;
  logic [1:0] prev_req    = 2'b00;
  rsp_t       held;

  always @(negedge Clk) begin
    if (reset) begin
      resp_active = 1'b0;
      prev_req    = 2'b00;
    end else begin
      if (SResp != 2'b00) begin
        if (!resp_active) begin
          if (rsp_q.size() == 0) begin
            chk("resp_unexpected", SResp, 2'b00);
            held.resp = SResp;
            held.data = SData;
          end else begin
            held = rsp_q.pop_front();
            chk("resp_code", SResp, held.resp);
            chk("resp_data", SData, held.data);
          end
        end else begin
          chk("resp_hold_code", SResp, held.resp);
          chk("resp_hold_data", SData, held.data);
        end
        resp_active = 1'b1;
      end else begin
        resp_active = 1'b0;
      end
      if ({write_request, read_request} != 2'b00 && prev_req == 2'b00) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", {write_request, read_request}, 2'b00);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_kind", {write_request, read_request}, e.kind);
          chk("req_addr", address, e.addr);
          chk("req_wdata", write_data, e.wd);
        end
      end
      prev_req = {write_request, read_request};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a command for one cycle, then check the one-cycle SCmdAccept.
  task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    MCmd  = cmd;
    MAddr = a;
    MData = d;
    tick();
    MCmd  = 3'b000;
    MAddr = '0;
    MData = '0;
    chk("accept_hi", SCmdAccept, 1'b1);
    tick();
    chk("accept_lo", SCmdAccept, 1'b0);
  endtask

  task automatic push_req(input logic [1:0] k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.kind = k; r.addr = a; r.wd = d;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic [1:0] c, input logic [DW-1:0] d);
    rsp_t r;
    r.resp = c; r.data = d;
    rsp_q.push_back(r);
  endtask

  task automatic accept_resp();
    MRespAccept = 1'b1;
    tick();
    MRespAccept = 1'b0;
    chk("resp_cleared", SResp, 2'b00);
    chk("sdata_cleared", SData, '0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acc"},  SCmdAccept, 1'b0);
    chk({tag, "_resp"}, SResp, 2'b00);
    chk({tag, "_data"}, SData, '0);
    chk({tag, "_addr"}, address, '0);
    chk({tag, "_wd"},   write_data, '0);
    chk({tag, "_reqs"}, {write_request, read_request}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; EnableClk = 1'b1; MCmd = 3'b000; MAddr = '0; MData = '0;
    MRespAccept = 1'b0; read_data = '0; tgt_ack = 1'b0; tgt_error = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // 1: read, ack two cycles after read_request
    push_req(2'b01, 64'h10, 8'h00);
    push_rsp(2'b01, 8'hA5);
    issue(3'b010, 64'h10, 8'h00);
    chk("t1_rdreq", read_request, 1'b1);
    tick(); tick();
    read_data = 8'hA5; tgt_ack = 1'b1;
    tick();
    tgt_ack = 1'b0; read_data = 8'h00;
    chk("t1_rdreq_off", read_request, 1'b0);
    chk("t1_dva", SResp, 2'b01);
    tick(); tick();
    accept_resp();

    // 2: posted write
    push_req(2'b10, 64'h20, 8'h3C);
    issue(3'b001, 64'h20, 8'h3C);
    chk("t2_wrreq", write_request, 1'b1);
    tick();
    chk("t2_wrreq_hold", write_request, 1'b1);
    tgt_ack = 1'b1;
    tick();
    tgt_ack = 1'b0;
    chk("t2_wrreq_off", write_request, 1'b0);
    chk("t2_no_resp", SResp, 2'b00);

    // 3: read timeout (issued immediately, so IDLE was reached right after the ack)
    push_req(2'b01, 64'h30, 8'h00);
    push_rsp(2'b11, 8'h00);
    read_data = 8'hEE;
    issue(3'b010, 64'h30, 8'h00);
    begin
      int n = 0;
      for (int i = 0; i < 10 && read_request; i++) begin
        n++;
        tick();
      end
      chk("t3_req_len", n, 5);
    end
    chk("t3_err", SResp, 2'b11);
    read_data = 8'h00;
    tick();
    accept_resp();

    // 4: unsupported command
    push_rsp(2'b11, 8'h00);
    issue(3'b011, 64'h44, 8'h99);
    chk("t4_noreq", {write_request, read_request}, 2'b00);
    chk("t4_err", SResp, 2'b11);
    tick();
    accept_resp();

    // 5: EnableClk gating in XFER and RESP
    push_req(2'b01, 64'h40, 8'h00);
    push_rsp(2'b01, 8'h5A);
    issue(3'b010, 64'h40, 8'h00);
    tick();
    EnableClk = 1'b0;
    read_data = 8'h5A;
    tgt_ack = 1'b1;
    tick(); tick(); tick(); tick();
    tgt_ack = 1'b0;
    chk("t5_frozen_req", read_request, 1'b1);
    chk("t5_frozen_resp", SResp, 2'b00);
    EnableClk = 1'b1;
    tick();
    chk("t5_no_timeout", SResp, 2'b00);
    tgt_ack = 1'b1;
    tick();
    tgt_ack = 1'b0; read_data = 8'h00;
    EnableClk = 1'b0; tick();
    EnableClk = 1'b1; tick();
    EnableClk = 1'b0; tick();
    EnableClk = 1'b0;
    MRespAccept = 1'b1;
    tick(); tick();
    chk("t5_accept_gated", SResp, 2'b01);
    EnableClk = 1'b1;
    tick();
    MRespAccept = 1'b0;
    chk("t5_cleared", SResp, 2'b00);

    // Posted write that fails is dropped without a response
    push_req(2'b10, 64'h70, 8'h81);
    issue(3'b001, 64'h70, 8'h81);
    tgt_ack = 1'b1; tgt_error = 1'b1;
    tick();
    tgt_ack = 1'b0; tgt_error = 1'b0;
    chk("wrerr_dropped", SResp, 2'b00);
    tick();

    // 6: async reset mid-XFER, then a normal read
    push_req(2'b01, 64'h50, 8'h00);
    issue(3'b010, 64'h50, 8'h00);
    tick();
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    tick();
    push_req(2'b01, 64'h60, 8'h00);
    push_rsp(2'b01, 8'h77);
    issue(3'b010, 64'h60, 8'h00);
    read_data = 8'h77; tgt_ack = 1'b1;
    tick();
    tgt_ack = 1'b0; read_data = 8'h00;
    chk("t6_dva", SResp, 2'b01);
    accept_resp();
    tick();

    chk("req_q_drained", req_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
